fc_spike_index_sched: RTL and testbench



---
 rtl/fc_spike_index_sched.sv | 139 +++++++++++++
 tb/tb_fc_spike_index_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_spike_index_sched.sv
// Ping-pong index buffer: producer fills one bank while the FC PE replays the other once per output channel.
// First beat follows the seal by one IDLE cycle, then 1 beat/cycle; wr_ready drops while both banks are sealed, and the PE stalls via s_index_ready.
module fc_spike_index_sched #(
  parameter int INDEX_WIDTH        = 16,
  parameter int DEPTH              = 128,
  parameter int ADDR_WIDTH         = 7,
  parameter int OUTPUT_CHANNEL_NUM = 256,
  parameter int CH_WIDTH           = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_valid,
  input  logic [INDEX_WIDTH-1:0] wr_index,
  input  logic                   wr_last,
  output logic                   wr_ready,
  output logic [INDEX_WIDTH-1:0] s_index_ram,
  output logic                   s_index_valid,
  input  logic                   s_index_ready,
  output logic [ADDR_WIDTH-1:0]  addr_most,
  output logic [CH_WIDTH-1:0]    channel_cnt,
  output logic                   frame_done,
  output logic [1:0]             bank_full
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t                 state, state_nxt;
  logic [INDEX_WIDTH-1:0] mem [2][DEPTH];
  logic [ADDR_WIDTH:0]    count [2];
  logic                   wr_bank, rd_bank;
  logic [ADDR_WIDTH-1:0]  wr_ptr, rd_ptr, rd_ptr_inc;
  logic                   wr_fire, wr_seal, rd_fire, rd_last_idx, rd_last_ch;

  assign wr_ready    = !bank_full[wr_bank];
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_seal     = wr_fire && (wr_last || wr_ptr == ADDR_WIDTH'(DEPTH - 1));
  assign rd_fire     = s_index_valid && s_index_ready;
  assign rd_ptr_inc  = rd_ptr + ADDR_WIDTH'(1);
  assign rd_last_idx = (rd_ptr == addr_most);
  assign rd_last_ch  = (channel_cnt == CH_WIDTH'(OUTPUT_CHANNEL_NUM - 1));

  // Index storage carries no reset; only sealed ranges are ever read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_ptr] <= wr_index;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr    <= '0;
      wr_bank   <= 1'b0;
      count[0]  <= '0;
      count[1]  <= '0;
      bank_full <= 2'b00;
    end else begin
      if (wr_fire) begin
        if (wr_seal) begin
          count[wr_bank]     <= (ADDR_WIDTH+1)'(wr_ptr) + (ADDR_WIDTH+1)'(1);
          bank_full[wr_bank] <= 1'b1;
          wr_ptr             <= '0;
          wr_bank            <= ~wr_bank;
        end else begin
          wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
        end
      end
      // A seal always targets the bank that is not being freed, so both may land together.
      if (state == DONE) begin
        bank_full[rd_bank] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = STREAM;
      STREAM:  if (rd_fire && rd_last_idx && rd_last_ch) state_nxt = DONE;
      DONE: begin
        state_nxt  = IDLE;
        frame_done = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_index_ram   <= '0;
      s_index_valid <= 1'b0;
      addr_most     <= '0;
      rd_ptr        <= '0;
      channel_cnt   <= '0;
      rd_bank       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bank_full[rd_bank]) begin
            s_index_ram   <= mem[rd_bank][0];
            addr_most     <= ADDR_WIDTH'(count[rd_bank] - (ADDR_WIDTH+1)'(1));
            rd_ptr        <= '0;
            channel_cnt   <= '0;
            s_index_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (rd_fire) begin
            if (!rd_last_idx) begin
              rd_ptr      <= rd_ptr_inc;
              s_index_ram <= mem[rd_bank][rd_ptr_inc];
            end else if (!rd_last_ch) begin
              rd_ptr      <= '0;
              channel_cnt <= channel_cnt + CH_WIDTH'(1);
              s_index_ram <= mem[rd_bank][0];
            end else begin
              s_index_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          rd_bank     <= ~rd_bank;
          channel_cnt <= '0;
          addr_most   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_spike_index_sched.sv
// Randomized bench for fc_spike_index_sched: frames are expanded by a queue-based model into
// the expected beat stream (index, channel, addr_most) and compared against captured PE beats.
module tb_fc_spike_index_sched;

  localparam int IW    = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int OCN   = 4;
  localparam int CW    = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          wr_valid = 1'b0;
  logic [IW-1:0] wr_index = '0;
  logic          wr_last = 1'b0;
  logic          wr_ready;
  logic [IW-1:0] s_index_ram;
  logic          s_index_valid;
  logic          s_index_ready = 1'b1;
  logic [AW-1:0] addr_most;
  logic [CW-1:0] channel_cnt;
  logic          frame_done;
  logic [1:0]    bank_full;

  fc_spike_index_sched #(
    .INDEX_WIDTH(IW), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .OUTPUT_CHANNEL_NUM(OCN), .CH_WIDTH(CW)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_last(wr_last), .wr_ready(wr_ready),
    .s_index_ram(s_index_ram), .s_index_valid(s_index_valid), .s_index_ready(s_index_ready),
    .addr_most(addr_most), .channel_cnt(channel_cnt), .frame_done(frame_done), .bank_full(bank_full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] ch;
    logic [AW-1:0] am;
  } beat_t;

  int errors = 0;
  int checks = 0;

  beat_t         exp_q[$];
  beat_t         got_q[$];
  int            got_cyc[$];
  int            done_cyc[$];
  logic [IW-1:0] cur_q[$];
  int            exp_frames = 0;
  int            done_cnt = 0;
  int            stall_bad = 0;
  int            wr_timeouts = 0;
  int            cyc = 0;
  int            rdy_mode = 0;

  // Reference: accepted indices group into frames closed by wr_last or by a full bank;
  // each frame is replayed in order once per output channel.
  function automatic void model_push(input logic [IW-1:0] idx, input bit last);
    cur_q.push_back(idx);
    if (last || cur_q.size() == DEPTH) begin
      for (int c = 0; c < OCN; c++)
        foreach (cur_q[k]) exp_q.push_back('{idx: cur_q[k], ch: CW'(c), am: AW'(cur_q.size() - 1)});
      exp_frames++;
      cur_q.delete();
    end
  endfunction

  // Capture accepted PE beats, frame_done pulses and any change during a stall.
  initial begin
    bit            prev_stall = 0;
    logic [IW-1:0] prev_idx = '0;
    logic [CW-1:0] prev_ch = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rstn) begin
        if (prev_stall && (s_index_valid !== 1'b1 || s_index_ram !== prev_idx || channel_cnt !== prev_ch))
          stall_bad++;
        prev_stall = s_index_valid && !s_index_ready;
        prev_idx   = s_index_ram;
        prev_ch    = channel_cnt;
        if (s_index_valid && s_index_ready) begin
          got_q.push_back('{idx: s_index_ram, ch: channel_cnt, am: addr_most});
          got_cyc.push_back(cyc);
        end
        if (frame_done) begin
          done_cnt++;
          done_cyc.push_back(cyc);
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       s_index_ready = 1'b1;
        1:       s_index_ready = (phase % 3 == 0);
        default: s_index_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  task automatic clear_all();
    exp_q.delete(); got_q.delete(); got_cyc.delete(); done_cyc.delete(); cur_q.delete();
    exp_frames = 0; done_cnt = 0; stall_bad = 0; wr_timeouts = 0;
  endtask

  task automatic wr_beat(input logic [IW-1:0] idx, input bit last);
    bit ok = 0;
    wr_valid = 1'b1; wr_index = idx; wr_last = last;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (wr_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_last = 1'b0;
    if (ok) model_push(idx, last);
    else wr_timeouts++;
  endtask

  task automatic wait_frames(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_cnt >= n) begin ok = 1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (wr_ready !== 1'b1)      begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    checks++; if (s_index_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", s_index_valid); end
    checks++; if (s_index_ram !== '0)     begin errors++; $display("FAIL reset_index got=%h exp=0", s_index_ram); end
    checks++; if (addr_most !== '0)       begin errors++; $display("FAIL reset_addr_most got=%0d exp=0", addr_most); end
    checks++; if (channel_cnt !== '0)     begin errors++; $display("FAIL reset_channel got=%0d exp=0", channel_cnt); end
    checks++; if (frame_done !== 1'b0)    begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (bank_full !== 2'b00)    begin errors++; $display("FAIL reset_bank_full got=%b exp=00", bank_full); end
  endtask

  task automatic test_basic();
    bit ok;
    clear_all(); rdy_mode = 0;
    wr_beat(16'd5, 0); wr_beat(16'd9, 0); wr_beat(16'd12, 1);
    wait_frames(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout frames=%0d exp=1", done_cnt); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    if (got_q.size() == 12 && done_cyc.size() == 1) begin
      checks++; if (got_cyc[11] - got_cyc[0] != 11) begin errors++; $display("FAIL basic_throughput span=%0d exp=11", got_cyc[11] - got_cyc[0]); end
      checks++; if (done_cyc[0] != got_cyc[11] + 1) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc[0], got_cyc[11] + 1); end
    end else begin
      checks++; errors++; $display("FAIL basic_shape beats=%0d done=%0d exp=12,1", got_q.size(), done_cyc.size());
    end
    checks++; if (bank_full !== 2'b00) begin errors++; $display("FAIL basic_bank_full got=%b exp=00", bank_full); end
  endtask

  task automatic test_stall();
    bit ok;
    clear_all(); rdy_mode = 1;
    wr_beat(16'd5, 0); wr_beat(16'd9, 0); wr_beat(16'd12, 1);
    wait_frames(1, ok);
    rdy_mode = 0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout frames=%0d exp=1", done_cnt); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_hold changes=%0d exp=0", stall_bad); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_pingpong();
    bit ok;
    clear_all(); rdy_mode = 0;
    wr_beat(16'd1, 0); wr_beat(16'd2, 1);
    wr_beat(16'd3, 1);
    checks++; if (wr_ready !== 1'b0 || bank_full !== 2'b11 || s_index_valid !== 1'b1) begin
      errors++; $display("FAIL pp_both_full wr_ready=%b bank_full=%b valid=%b exp=0,11,1", wr_ready, bank_full, s_index_valid);
    end
    wr_beat(16'd4, 1);
    checks++; if (done_cnt < 1) begin errors++; $display("FAIL pp_c_early frames_done=%0d exp>=1", done_cnt); end
    wait_frames(3, ok);
    checks++; if (!ok || wr_timeouts != 0) begin errors++; $display("FAIL pp_timeout frames=%0d wr_timeouts=%0d exp=3,0", done_cnt, wr_timeouts); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL pp_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL pp_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    if (got_q.size() > 8 && done_cyc.size() > 0) begin
      checks++; if (got_cyc[8] > done_cyc[0] + 2) begin errors++; $display("FAIL pp_b_gap first_b=%0d exp<=%0d", got_cyc[8], done_cyc[0] + 2); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_all(); rdy_mode = 0;
    for (int i = 0; i < 10; i++) wr_beat(IW'(i), i == 9);
    wait_frames(2, ok);
    checks++; if (!ok || exp_frames != 2) begin errors++; $display("FAIL ovf_frames got=%0d model=%0d exp=2", done_cnt, exp_frames); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL ovf_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_all(); rdy_mode = 0;
    wr_beat(16'd7, 1);
    wait_frames(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout frames=%0d exp=1", done_cnt); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL single_count got=%0d exp=4", got_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    clear_all(); rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      int len = $urandom_range(1, 11);
      for (int k = 0; k < len; k++) begin
        logic [IW-1:0] v = IW'($urandom);
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        wr_beat(v, k == len - 1);
      end
    end
    wait_frames(exp_frames, ok);
    rdy_mode = 0;
    checks++; if (!ok || wr_timeouts != 0) begin errors++; $display("FAIL rnd_timeout frames=%0d exp=%0d wr_timeouts=%0d", done_cnt, exp_frames, wr_timeouts); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL rnd_stall_hold changes=%0d exp=0", stall_bad); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rnd_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit found = 0;
    int done_before;
    clear_all(); rdy_mode = 0;
    wr_beat(16'd10, 0); wr_beat(16'd11, 0); wr_beat(16'd12, 1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_index_valid && channel_cnt == 2) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_ch2 got=0 exp=1"); end
    done_before = done_cnt;
    rstn = 1'b0;
    #1;
    checks++; if (s_index_valid !== 1'b0 || channel_cnt !== '0 || addr_most !== '0 || s_index_ram !== '0) begin
      errors++; $display("FAIL rstmid_outputs valid=%b ch=%0d am=%0d idx=%h exp=0,0,0,0", s_index_valid, channel_cnt, addr_most, s_index_ram);
    end
    checks++; if (wr_ready !== 1'b1 || bank_full !== 2'b00 || frame_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl wr_ready=%b bank_full=%b done=%b exp=1,00,0", wr_ready, bank_full, frame_done);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (done_cnt != done_before) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, done_before); end
    @(posedge clk); #1;
    clear_all();
    wr_beat(16'd21, 0); wr_beat(16'd22, 1);
    wait_frames(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_new_timeout frames=%0d exp=1", done_cnt); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rstmid_beat[%0d] got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    rstn = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_pingpong();
    test_overflow();
    test_single();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
